// File: rtl/act_w_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : act_w_loader_pkg
//  Purpose  : Shared types and default sizes for the ACT/W SRAM loader.
//  Revision : 1.0 - initial release
// ============================================================================
package act_w_loader_pkg;

  localparam int DEF_BW        = 32;
  localparam int DEF_ADDR_BW   = 7;
  localparam int DEF_ACT_WORDS = 36;
  localparam int DEF_W_WORDS   = 72;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_ACT  = 3'd1,
    LOAD_W    = 3'd2,
    FLUSH     = 3'd3,
    LAUNCH    = 3'd4,
    WAIT_DONE = 3'd5,
    DONE      = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/act_w_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : act_w_loader_if
//  Purpose  : Host stream, ACT/W SRAM write ports and corelet handoff signals.
//  Revision : 1.0 - initial release
// ============================================================================
interface act_w_loader_if #(
  parameter int BW      = 32,
  parameter int ADDR_BW = 7
);
  logic [BW-1:0]      in_data;
  logic               in_valid;
  logic               in_ready;
  logic [BW-1:0]      act_d;
  logic [ADDR_BW-1:0] act_addr;
  logic               act_cen;
  logic               act_wen;
  logic [BW-1:0]      w_d;
  logic [ADDR_BW-1:0] w_addr;
  logic               w_cen;
  logic               w_wen;
  logic               cl_sel;
  logic               seq_begin;
  logic               seq_done;

  // Loader view
  modport master (
    input  in_data, in_valid, seq_done,
    output in_ready, act_d, act_addr, act_cen, act_wen,
           w_d, w_addr, w_cen, w_wen, cl_sel, seq_begin
  );

  // Host/core view
  modport slave (
    output in_data, in_valid, seq_done,
    input  in_ready, act_d, act_addr, act_cen, act_wen,
           w_d, w_addr, w_cen, w_wen, cl_sel, seq_begin
  );
endinterface
`default_nettype wire

// File: rtl/act_w_loader_sram_wr_port.sv
`default_nettype none
// ============================================================================
//  Module   : sram_wr_port
//  Purpose  : Registered SRAM write stage. An enabled cycle produces exactly
//             one write-strobe cycle (cen/wen low) on the following cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module sram_wr_port #(
  parameter int BW      = 32,
  parameter int ADDR_BW = 7
) (
  input  wire logic               clk,
  input  wire logic               reset,
  input  wire logic               en_i,
  input  wire logic [BW-1:0]      d_i,
  input  wire logic [ADDR_BW-1:0] addr_i,
  output      logic [BW-1:0]      d_o,
  output      logic [ADDR_BW-1:0] addr_o,
  output      logic               cen_o,
  output      logic               wen_o
);

  logic [BW-1:0]      d_q;
  logic [ADDR_BW-1:0] addr_q;
  logic               cen_q;
  logic               wen_q;

  // Capture a write when enabled; otherwise idle the strobes and hold d/addr
  always_ff @(posedge clk) begin
    if (reset) begin
      d_q    <= '0;
      addr_q <= '0;
      cen_q  <= 1'b1;
      wen_q  <= 1'b1;
    end else if (en_i) begin
      d_q    <= d_i;
      addr_q <= addr_i;
      cen_q  <= 1'b0;
      wen_q  <= 1'b0;
    end else begin
      cen_q  <= 1'b1;
      wen_q  <= 1'b1;
    end
  end

  assign d_o    = d_q;
  assign addr_o = addr_q;
  assign cen_o  = cen_q;
  assign wen_o  = wen_q;

endmodule
`default_nettype wire

// File: rtl/act_w_loader.sv
`default_nettype none
// ============================================================================
//  Module   : act_w_loader
//  Purpose  : Streams ACT then W words into the core SRAMs, hands SRAM
//             ownership to the corelet, launches it and waits for completion.
//  Revision : 1.0 - initial release
// ============================================================================
module act_w_loader
  import act_w_loader_pkg::*;
#(
  parameter int BW        = DEF_BW,
  parameter int ADDR_BW   = DEF_ADDR_BW,
  parameter int ACT_WORDS = DEF_ACT_WORDS,
  parameter int W_WORDS   = DEF_W_WORDS
) (
  input  wire logic       clk,
  input  wire logic       reset,
  input  wire logic       start_i,
  output      logic       busy_o,
  output      logic       done_o,
  act_w_loader_if.master  bus
);

  // Terminal counts checked before increment, so the counter never wraps
  localparam logic [ADDR_BW-1:0] ACT_LAST = ADDR_BW'(ACT_WORDS - 1);
  localparam logic [ADDR_BW-1:0] W_LAST   = ADDR_BW'(W_WORDS - 1);

  state_t             state_q, state_d;
  logic [ADDR_BW-1:0] cnt_q, cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               cl_sel_q, cl_sel_d;
  logic               seq_begin_q, seq_begin_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               beat;
  logic               act_en;
  logic               w_en;

  assign beat   = bus.in_valid & in_ready_q;
  assign act_en = beat & (state_q == LOAD_ACT);
  assign w_en   = beat & (state_q == LOAD_W);

  // Next state, beat counter, and registered outputs decoded from the next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = LOAD_ACT;
          cnt_d   = '0;
        end
      end
      LOAD_ACT: begin
        if (beat) begin
          if (cnt_q == ACT_LAST) begin
            state_d = LOAD_W;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      LOAD_W: begin
        if (beat) begin
          if (cnt_q == W_LAST) begin
            state_d = FLUSH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FLUSH:     state_d = LAUNCH;
      LAUNCH:    state_d = WAIT_DONE;
      WAIT_DONE: if (bus.seq_done) state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    in_ready_d  = (state_d == LOAD_ACT) || (state_d == LOAD_W);
    cl_sel_d    = !((state_d == LAUNCH) || (state_d == WAIT_DONE));
    seq_begin_d = (state_d == LAUNCH);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  // State, counter and control-output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      cl_sel_q    <= 1'b1;
      seq_begin_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      cl_sel_q    <= cl_sel_d;
      seq_begin_q <= seq_begin_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  sram_wr_port #(.BW(BW), .ADDR_BW(ADDR_BW)) u_act_port (
    .clk    (clk),
    .reset  (reset),
    .en_i   (act_en),
    .d_i    (bus.in_data),
    .addr_i (cnt_q),
    .d_o    (bus.act_d),
    .addr_o (bus.act_addr),
    .cen_o  (bus.act_cen),
    .wen_o  (bus.act_wen)
  );

  sram_wr_port #(.BW(BW), .ADDR_BW(ADDR_BW)) u_w_port (
    .clk    (clk),
    .reset  (reset),
    .en_i   (w_en),
    .d_i    (bus.in_data),
    .addr_i (cnt_q),
    .d_o    (bus.w_d),
    .addr_o (bus.w_addr),
    .cen_o  (bus.w_cen),
    .wen_o  (bus.w_wen)
  );

  assign bus.in_ready  = in_ready_q;
  assign bus.cl_sel    = cl_sel_q;
  assign bus.seq_begin = seq_begin_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_act_w_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_act_w_loader
//  Purpose  : Directed self-checking bench for act_w_loader.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_act_w_loader;
  import act_w_loader_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic busy;
  logic done;

  act_w_loader_if #(.BW(DEF_BW), .ADDR_BW(DEF_ADDR_BW)) bus ();

  act_w_loader #(
    .BW(DEF_BW), .ADDR_BW(DEF_ADDR_BW), .ACT_WORDS(DEF_ACT_WORDS), .W_WORDS(DEF_W_WORDS)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start_i (start),
    .busy_o  (busy),
    .done_o  (done),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int overlap = 0;
  int act_addr_q[$], act_data_q[$], act_cyc_q[$];
  int w_addr_q[$], w_data_q[$], w_cyc_q[$];
  int acc_cyc_q[$];

  // Record accepted beats with the cycle number of the accepting edge
  always @(posedge clk) begin
    if (bus.in_valid && bus.in_ready && !reset) acc_cyc_q.push_back(cyc);
    cyc = cyc + 1;
  end

  // Record SRAM write strobes mid-cycle
  always @(negedge clk) begin
    if (!bus.act_cen && !bus.act_wen) begin
      act_addr_q.push_back(int'(bus.act_addr));
      act_data_q.push_back(int'(bus.act_d));
      act_cyc_q.push_back(cyc);
    end
    if (!bus.w_cen && !bus.w_wen) begin
      w_addr_q.push_back(int'(bus.w_addr));
      w_data_q.push_back(int'(bus.w_d));
      w_cyc_q.push_back(cyc);
    end
    if (!bus.act_cen && !bus.w_cen) overlap++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    act_addr_q.delete(); act_data_q.delete(); act_cyc_q.delete();
    w_addr_q.delete(); w_data_q.delete(); w_cyc_q.delete();
    acc_cyc_q.delete();
    overlap = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Push n words (first, first+1, ...); optional random gaps and side pulses at a beat index
  task automatic stream(input int n, input int first, input bit gaps,
                        input int start_at, input int done_at);
    int i = 0;
    int guard = 0;
    bit acc;
    while (i < n && guard < 3000) begin
      guard++;
      if (gaps && $urandom_range(0, 1) == 0) begin
        bus.in_valid = 1'b0;
        tick();
      end else begin
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'(first + i);
        start         = (i == start_at);
        bus.seq_done  = (i == done_at);
        acc = bus.in_ready;
        tick();
        start        = 1'b0;
        bus.seq_done = 1'b0;
        if (acc) i++;
      end
    end
    if (i < n) begin
      cmp_cnt++; err_cnt++;
      $display("FAIL stream_timeout: accepted %0d required %0d", i, n);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 32'd999;
  endtask

  // Bounded wait until seq_begin is seen
  task automatic wait_seq_begin();
    int k = 0;
    while (!bus.seq_begin && k < 20) begin
      tick();
      k++;
    end
    cmp_cnt++;
    if (bus.seq_begin !== 1'b1) begin
      err_cnt++;
      $display("FAIL seq_begin_timeout: got %b required 1", bus.seq_begin);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.seq_done = 1'b0;
    tick(); tick();
    start = 1'b1;                 // coincident with reset: must be ignored
    tick();
    start = 1'b0;
    cmp_cnt++;
    if ({bus.act_cen, bus.act_wen, bus.w_cen, bus.w_wen} !== 4'hF) begin
      err_cnt++;
      $display("FAIL reset_strobes: got %h required f", {bus.act_cen, bus.act_wen, bus.w_cen, bus.w_wen});
    end
    cmp_cnt++;
    if ({bus.in_ready, busy, done, bus.seq_begin, bus.cl_sel} !== 5'b00001) begin
      err_cnt++;
      $display("FAIL reset_ctrl: got %b required 00001", {bus.in_ready, busy, done, bus.seq_begin, bus.cl_sel});
    end
    cmp_cnt++;
    if ({bus.act_addr, bus.w_addr, bus.act_d, bus.w_d} !== '0) begin
      err_cnt++;
      $display("FAIL reset_addr_data: got %h/%h/%h/%h required 0", bus.act_addr, bus.w_addr, bus.act_d, bus.w_d);
    end
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      cmp_cnt++;
      if ({bus.in_ready, busy, done, bus.seq_begin, bus.cl_sel,
           bus.act_cen, bus.act_wen, bus.w_cen, bus.w_wen} !== 9'b000011111) begin
        err_cnt++;
        $display("FAIL idle_hold[%0d]: got %b required 000011111", k,
                 {bus.in_ready, busy, done, bus.seq_begin, bus.cl_sel,
                  bus.act_cen, bus.act_wen, bus.w_cen, bus.w_wen});
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    pulse_start();
    cmp_cnt++;
    if ({busy, bus.in_ready, bus.cl_sel} !== 3'b111) begin
      err_cnt++;
      $display("FAIL load_entry: got %b required 111", {busy, bus.in_ready, bus.cl_sel});
    end
    stream(108, 0, 1'b0, -1, -1);
    // FLUSH: last W write on the pins, stream closed
    cmp_cnt++;
    if ({bus.in_ready, bus.cl_sel, bus.seq_begin, bus.w_cen, bus.w_wen} !== 5'b01000) begin
      err_cnt++;
      $display("FAIL flush_ctrl: got %b required 01000", {bus.in_ready, bus.cl_sel, bus.seq_begin, bus.w_cen, bus.w_wen});
    end
    cmp_cnt++;
    if (bus.w_addr !== 7'd71 || bus.w_d !== 32'd107) begin
      err_cnt++;
      $display("FAIL flush_last_w: got addr %0d data %0d required 71/107", bus.w_addr, bus.w_d);
    end
    tick();
    // LAUNCH
    cmp_cnt++;
    if ({bus.seq_begin, bus.cl_sel, bus.act_cen, bus.act_wen, bus.w_cen, bus.w_wen, bus.in_ready} !== 7'b1011110) begin
      err_cnt++;
      $display("FAIL launch: got %b required 1011110",
               {bus.seq_begin, bus.cl_sel, bus.act_cen, bus.act_wen, bus.w_cen, bus.w_wen, bus.in_ready});
    end
    bus.in_valid = 1'b0;
    tick();
    // WAIT_DONE
    cmp_cnt++;
    if ({bus.seq_begin, bus.cl_sel, busy, done} !== 4'b0010) begin
      err_cnt++;
      $display("FAIL wait_done_entry: got %b required 0010", {bus.seq_begin, bus.cl_sel, busy, done});
    end
    cmp_cnt++;
    if (act_addr_q.size() !== 36 || w_addr_q.size() !== 72) begin
      err_cnt++;
      $display("FAIL b2b_counts: got act %0d w %0d required 36/72", act_addr_q.size(), w_addr_q.size());
    end else begin
      for (int i = 0; i < 36; i++) begin
        cmp_cnt++;
        if (act_addr_q[i] !== i || act_data_q[i] !== i) begin
          err_cnt++;
          $display("FAIL b2b_act[%0d]: got addr %0d data %0d required %0d/%0d", i, act_addr_q[i], act_data_q[i], i, i);
        end
      end
      for (int i = 0; i < 72; i++) begin
        cmp_cnt++;
        if (w_addr_q[i] !== i || w_data_q[i] !== 36 + i) begin
          err_cnt++;
          $display("FAIL b2b_w[%0d]: got addr %0d data %0d required %0d/%0d", i, w_addr_q[i], w_data_q[i], i, 36 + i);
        end
      end
    end
    cmp_cnt++;
    if (overlap !== 0) begin
      err_cnt++;
      $display("FAIL b2b_overlap: got %0d required 0", overlap);
    end
  endtask

  // Continues from the first WAIT_DONE cycle of the previous run
  task automatic test_seq_done();
    int bad = 0;
    for (int k = 0; k < 19; k++) begin
      tick();
      if (done || bus.cl_sel || !busy) bad++;
    end
    cmp_cnt++;
    if (bad !== 0) begin
      err_cnt++;
      $display("FAIL waiting_hold: got %0d bad cycles required 0", bad);
    end
    bus.seq_done = 1'b1;
    tick();
    bus.seq_done = 1'b0;
    cmp_cnt++;
    if ({done, bus.cl_sel, busy} !== 3'b111) begin
      err_cnt++;
      $display("FAIL done_pulse: got %b required 111", {done, bus.cl_sel, busy});
    end
    tick();
    cmp_cnt++;
    if ({done, bus.cl_sel, busy, bus.in_ready} !== 4'b0100) begin
      err_cnt++;
      $display("FAIL after_done: got %b required 0100", {done, bus.cl_sel, busy, bus.in_ready});
    end
  endtask

  task automatic test_gaps();
    clear_logs();
    pulse_start();
    stream(108, 1000, 1'b1, -1, -1);
    bus.in_valid = 1'b0;
    wait_seq_begin();
    cmp_cnt++;
    if (act_addr_q.size() !== 36 || w_addr_q.size() !== 72 || acc_cyc_q.size() !== 108) begin
      err_cnt++;
      $display("FAIL gap_counts: got act %0d w %0d beats %0d required 36/72/108",
               act_addr_q.size(), w_addr_q.size(), acc_cyc_q.size());
    end else begin
      for (int i = 0; i < 36; i++) begin
        cmp_cnt++;
        if (act_addr_q[i] !== i || act_data_q[i] !== 1000 + i || act_cyc_q[i] !== acc_cyc_q[i] + 1) begin
          err_cnt++;
          $display("FAIL gap_act[%0d]: got addr %0d data %0d cyc %0d required %0d/%0d/%0d",
                   i, act_addr_q[i], act_data_q[i], act_cyc_q[i], i, 1000 + i, acc_cyc_q[i] + 1);
        end
      end
      for (int i = 0; i < 72; i++) begin
        cmp_cnt++;
        if (w_addr_q[i] !== i || w_data_q[i] !== 1036 + i || w_cyc_q[i] !== acc_cyc_q[36 + i] + 1) begin
          err_cnt++;
          $display("FAIL gap_w[%0d]: got addr %0d data %0d cyc %0d required %0d/%0d/%0d",
                   i, w_addr_q[i], w_data_q[i], w_cyc_q[i], i, 1036 + i, acc_cyc_q[36 + i] + 1);
        end
      end
    end
    tick();
    bus.seq_done = 1'b1;
    tick();
    bus.seq_done = 1'b0;
    cmp_cnt++;
    if (done !== 1'b1) begin
      err_cnt++;
      $display("FAIL gap_done: got %b required 1", done);
    end
    tick();
  endtask

  task automatic test_ignored();
    clear_logs();
    pulse_start();
    // seq_done during LOAD_ACT (beat 5), start during LOAD_W (beat 50)
    stream(108, 2000, 1'b0, 50, 5);
    bus.in_valid = 1'b0;
    wait_seq_begin();
    cmp_cnt++;
    if (act_addr_q.size() !== 36 || w_addr_q.size() !== 72) begin
      err_cnt++;
      $display("FAIL ign_counts: got act %0d w %0d required 36/72", act_addr_q.size(), w_addr_q.size());
    end else begin
      cmp_cnt++;
      if (act_addr_q[35] !== 35 || act_data_q[35] !== 2035 || w_addr_q[71] !== 71 || w_data_q[71] !== 2107) begin
        err_cnt++;
        $display("FAIL ign_last: got act %0d/%0d w %0d/%0d required 35/2035 71/2107",
                 act_addr_q[35], act_data_q[35], w_addr_q[71], w_data_q[71]);
      end
    end
    tick();
    start = 1'b1;                 // start while in WAIT_DONE
    tick();
    start = 1'b0;
    repeat (5) tick();
    cmp_cnt++;
    if ({busy, bus.cl_sel, done, bus.in_ready} !== 4'b1000) begin
      err_cnt++;
      $display("FAIL ign_wait: got %b required 1000", {busy, bus.cl_sel, done, bus.in_ready});
    end
    bus.seq_done = 1'b1;
    tick();
    bus.seq_done = 1'b0;
    cmp_cnt++;
    if (done !== 1'b1) begin
      err_cnt++;
      $display("FAIL ign_done: got %b required 1", done);
    end
    repeat (3) tick();
    cmp_cnt++;
    if ({busy, bus.in_ready} !== 2'b00) begin
      err_cnt++;
      $display("FAIL ign_no_rerun: got %b required 00", {busy, bus.in_ready});
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    pulse_start();
    stream(10, 3000, 1'b0, -1, -1);
    cmp_cnt++;
    if (bus.act_cen !== 1'b0 || bus.act_addr !== 7'd9 || bus.act_d !== 32'd3009) begin
      err_cnt++;
      $display("FAIL mid_pre: got cen %b addr %0d data %0d required 0/9/3009", bus.act_cen, bus.act_addr, bus.act_d);
    end
    reset = 1'b1;
    tick();
    cmp_cnt++;
    if ({bus.in_ready, busy, bus.cl_sel, bus.seq_begin, done,
         bus.act_cen, bus.act_wen, bus.w_cen, bus.w_wen} !== 9'b001001111) begin
      err_cnt++;
      $display("FAIL mid_reset: got %b required 001001111",
               {bus.in_ready, busy, bus.cl_sel, bus.seq_begin, done,
                bus.act_cen, bus.act_wen, bus.w_cen, bus.w_wen});
    end
    cmp_cnt++;
    if (bus.act_addr !== 7'd0 || bus.act_d !== 32'd0) begin
      err_cnt++;
      $display("FAIL mid_reset_addr: got %0d/%0d required 0/0", bus.act_addr, bus.act_d);
    end
    reset = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    clear_logs();
    pulse_start();
    stream(3, 4000, 1'b0, -1, -1);
    bus.in_valid = 1'b0;
    tick(); tick();
    cmp_cnt++;
    if (act_addr_q.size() !== 3) begin
      err_cnt++;
      $display("FAIL restart_count: got %0d required 3", act_addr_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        cmp_cnt++;
        if (act_addr_q[i] !== i || act_data_q[i] !== 4000 + i) begin
          err_cnt++;
          $display("FAIL restart[%0d]: got %0d/%0d required %0d/%0d", i, act_addr_q[i], act_data_q[i], i, 4000 + i);
        end
      end
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_seq_done();
    test_gaps();
    test_ignored();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
